// File: rtl/fetch_pkg.sv
`default_nettype none
//==========================================================================
// fetch_pkg: state encoding and constants shared by the fetch stage.  Rev 1.0
//==========================================================================
package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_REQ  = 2'd0,
      FS_WAIT = 2'd1,
      FS_DROP = 2'd2
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
//==========================================================================
// fetch_buf: 1-entry PC+instruction holding register (built only with
// FETCH_BUF_EN defined).  Rev 1.0
//==========================================================================
`ifdef FETCH_BUF_EN
module fetch_buf import fetch_pkg::*; (
   input  logic            clk,
   input  logic            rstn,
   input  logic            clear,
   input  logic            load,
   input  logic            drain,
   input  logic [XLEN-1:0] load_pc,
   input  logic [XLEN-1:0] load_inst,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] inst
);

   // A load in the same cycle as a drain refills the entry.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid <= 1'b0;
         pc    <= '0;
         inst  <= NOP_INST;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= load_pc;
         inst  <= load_inst;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule
`endif
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
//==========================================================================
// fetch_stage: RV32I instruction fetch + IF/ID register; FETCH_BUF_EN adds
// a response buffer instead of refetching on stall.  Rev 1.0
//==========================================================================
module fetch_stage import fetch_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            PCWr,
   input  logic            IF_ID_Wr,
   input  logic            flush,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] IF_ID_PC,
   output logic [XLEN-1:0] IF_ID_Inst,
   output logic            IF_ID_valid,
   output logic [4:0]      IF_ID_Rs1,
   output logic [4:0]      IF_ID_Rs2
);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc, pc_req;
   logic            resp_now, resp_taken, slot_free, replay, accept;
   logic            buf_valid;
   logic [XLEN-1:0] buf_pc, buf_inst;
   logic            ifid_ld, ifid_valid_nxt;
   logic [XLEN-1:0] ifid_pc_nxt, ifid_inst_nxt;

   assign resp_now   = (state == FS_WAIT) & imem_rvalid;
   assign resp_taken = IF_ID_Wr & ~buf_valid;

`ifdef FETCH_BUF_EN
   logic buf_load, buf_drain;

   assign slot_free = ~buf_valid;
   assign buf_drain = ~flush & IF_ID_Wr & buf_valid;
   // Capture while stalled, or refill behind an entry being drained.
   assign buf_load  = ~flush & resp_now & (buf_valid ? IF_ID_Wr : ~IF_ID_Wr);
   assign replay    = ~flush & resp_now & ~IF_ID_Wr & buf_valid;

   fetch_buf u_fetch_buf (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (flush),
      .load      (buf_load),
      .drain     (buf_drain),
      .load_pc   (pc_req),
      .load_inst (imem_rdata),
      .valid     (buf_valid),
      .pc        (buf_pc),
      .inst      (buf_inst)
   );
`else
   assign slot_free = 1'b1;
   assign buf_valid = 1'b0;
   assign buf_pc    = '0;
   assign buf_inst  = NOP_INST;
   // A response that cannot enter IF/ID is dropped and fetched again.
   assign replay    = ~flush & resp_now & ~IF_ID_Wr;
`endif

   assign imem_req  = rstn & PCWr & ~flush & slot_free &
                      ((state == FS_REQ) | (resp_now & resp_taken) |
                       ((state == FS_DROP) & imem_rvalid));
   assign imem_addr = pc;
   assign accept    = imem_req & imem_ready;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= FS_REQ;
         pc     <= RESET_PC;
         pc_req <= RESET_PC;
      end else begin
         state <= state_nxt;
         if (flush)
            pc <= redirect_pc;
         else if (replay)
            pc <= pc_req;
         else if (accept)
            pc <= pc + XLEN'(4);
         if (accept)
            pc_req <= pc;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FS_REQ:
            if (accept)
               state_nxt = FS_WAIT;
         FS_WAIT:
            if (flush)
               state_nxt = imem_rvalid ? FS_REQ : FS_DROP;
            else if (imem_rvalid)
               state_nxt = accept ? FS_WAIT : FS_REQ;
         // A stale response arriving with a flush is consumed, so leave DROP.
         FS_DROP:
            if (imem_rvalid)
               state_nxt = accept ? FS_WAIT : FS_REQ;
         default:
            state_nxt = FS_REQ;
      endcase
   end

   always_comb begin
      ifid_ld        = 1'b0;
      ifid_pc_nxt    = IF_ID_PC;
      ifid_inst_nxt  = NOP_INST;
      ifid_valid_nxt = 1'b0;
      if (flush) begin
         ifid_ld = 1'b1;
      end else if (IF_ID_Wr) begin
         ifid_ld = 1'b1;
         if (buf_valid) begin
            ifid_pc_nxt    = buf_pc;
            ifid_inst_nxt  = buf_inst;
            ifid_valid_nxt = 1'b1;
         end else if (resp_now) begin
            ifid_pc_nxt    = pc_req;
            ifid_inst_nxt  = imem_rdata;
            ifid_valid_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         IF_ID_PC    <= '0;
         IF_ID_Inst  <= NOP_INST;
         IF_ID_valid <= 1'b0;
      end else if (ifid_ld) begin
         IF_ID_PC    <= ifid_pc_nxt;
         IF_ID_Inst  <= ifid_inst_nxt;
         IF_ID_valid <= ifid_valid_nxt;
      end
   end

   assign IF_ID_Rs1 = IF_ID_Inst[19:15];
   assign IF_ID_Rs2 = IF_ID_Inst[24:20];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
//==========================================================================
// tb_fetch_stage: directed vectors plus randomized run against an
// instruction-stream reference model.  Rev 1.0
//==========================================================================
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_BUF_EN
   localparam logic [31:0] C5_ADDR  = 32'h10;
   localparam logic        C6_REQ   = 1'b0;
   localparam logic [31:0] C6_ADDR  = 32'h10;
   localparam int          EXP_HITS = 1;
`else
   localparam logic [31:0] C5_ADDR  = 32'hC;
   localparam logic        C6_REQ   = 1'b1;
   localparam logic [31:0] C6_ADDR  = 32'hC;
   localparam int          EXP_HITS = 2;
`endif

   logic        clk = 1'b0;
   logic        rstn, PCWr, IF_ID_Wr, flush, imem_ready;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata  = '0;
   logic [31:0] IF_ID_PC, IF_ID_Inst;
   logic        IF_ID_valid;
   logic [4:0]  IF_ID_Rs1, IF_ID_Rs2;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
      .clk(clk), .rstn(rstn), .PCWr(PCWr), .IF_ID_Wr(IF_ID_Wr), .flush(flush),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .IF_ID_PC(IF_ID_PC), .IF_ID_Inst(IF_ID_Inst), .IF_ID_valid(IF_ID_valid),
      .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0135_7BDF;
   endfunction

   // Instruction memory: one request at a time, latency lat_now cycles.
   int          lat_now = 1;
   logic        mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;

   always @(posedge clk) begin
      if (!rstn) begin
         mem_busy    <= 1'b0;
         mem_cnt     <= 0;
         imem_rvalid <= 1'b0;
      end else begin
         imem_rvalid <= 1'b0;
         if (imem_req && imem_ready) begin
            if (lat_now <= 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= memf(imem_addr);
               mem_busy    <= 1'b0;
            end else begin
               mem_busy <= 1'b1;
               mem_cnt  <= lat_now - 1;
               mem_addr <= imem_addr;
            end
         end else if (mem_busy) begin
            if (mem_cnt <= 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= memf(mem_addr);
               mem_busy    <= 1'b0;
            end else begin
               mem_cnt <= mem_cnt - 1;
            end
         end
      end
   end

   int          total = 0, bad = 0;
   logic [31:0] exp_next = '0;
   int          gap = 0, loads = 0, hits = 0;
   logic [31:0] cnt_addr = 32'h1;
   logic        last_acc = 1'b0;
   logic [31:0] last_acc_addr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: called just after a negedge with inputs applied, returns at
   // the next negedge. The stream model expects valid IF/ID PCs in program
   // order from RESET_PC, restarting at redirect_pc after each flush.
   task automatic tick();
      logic        p_rstn, p_flush, p_wr, p_pcwr, p_req, p_ready, p_busy, o_valid;
      logic [31:0] p_addr, p_redir, o_pc, o_inst;
      #1;
      p_rstn = rstn; p_flush = flush; p_wr = IF_ID_Wr; p_pcwr = PCWr;
      p_req = imem_req; p_ready = imem_ready; p_busy = mem_busy;
      p_addr = imem_addr; p_redir = redirect_pc;
      o_pc = IF_ID_PC; o_inst = IF_ID_Inst; o_valid = IF_ID_valid;
      if (!p_rstn || p_flush || !p_pcwr)
         chk("req gated", 32'(p_req), 32'd0);
      last_acc = p_req && p_ready;
      if (last_acc) begin
         chk("one outstanding", 32'(p_busy), 32'd0);
         last_acc_addr = p_addr;
         if (p_addr == cnt_addr) hits++;
      end
      @(posedge clk);
      #1;
      if (!p_rstn) begin
         chk("reset pc", IF_ID_PC, 32'h0);
         chk("reset inst", IF_ID_Inst, NOP);
         chk("reset valid", 32'(IF_ID_valid), 32'd0);
         exp_next = 32'h0;
         gap = 0;
      end else if (p_flush) begin
         chk("flush valid", 32'(IF_ID_valid), 32'd0);
         chk("flush inst", IF_ID_Inst, NOP);
         chk("flush pc", IF_ID_PC, o_pc);
         exp_next = p_redir;
         gap = 0;
      end else if (!p_wr) begin
         chk("hold pc", IF_ID_PC, o_pc);
         chk("hold inst", IF_ID_Inst, o_inst);
         chk("hold valid", 32'(IF_ID_valid), 32'(o_valid));
      end else if (IF_ID_valid) begin
         chk("stream pc", IF_ID_PC, exp_next);
         chk("stream inst", IF_ID_Inst, memf(exp_next));
         chk("progress gap", 32'(gap <= 40), 32'd1);
         exp_next = exp_next + 32'd4;
         gap = 0;
         loads++;
      end else begin
         chk("bubble pc", IF_ID_PC, o_pc);
         chk("bubble inst", IF_ID_Inst, NOP);
         gap++;
      end
      chk("rs1", 32'(IF_ID_Rs1), 32'(IF_ID_Inst[19:15]));
      chk("rs2", 32'(IF_ID_Rs2), 32'(IF_ID_Inst[24:20]));
      @(negedge clk);
   endtask

   task automatic wait_valid(input string name, input logic [31:0] exp_pc);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!IF_ID_valid && n < 40);
      chk({name, " valid"}, 32'(IF_ID_valid), 32'd1);
      chk({name, " pc"}, IF_ID_PC, exp_pc);
      chk({name, " inst"}, IF_ID_Inst, memf(exp_pc));
   endtask

   task automatic wait_accept(input logic [31:0] a);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(last_acc && last_acc_addr == a) && n < 60);
      chk("accept addr", last_acc ? last_acc_addr : 32'hDEAD_BEEF, a);
   endtask

   typedef struct {
      logic        pcwr;
      logic        wr;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [31:0] exp_pc;
      logic        exp_valid;
   } vec_t;

   initial begin
      vec_t        vecs[7];
      int          loads0;
      logic [31:0] r;
      vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 32'h0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h0, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 32'h0, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 32'h4, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h8, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 1'b0, C5_ADDR, 32'h8, 1'b1};
      vecs[6] = '{1'b1, 1'b1, C6_REQ, C6_ADDR, 32'h8, 1'b1};

      rstn = 1'b0; PCWr = 1'b1; IF_ID_Wr = 1'b1; flush = 1'b0;
      redirect_pc = '0; imem_ready = 1'b1; lat_now = 1;
      @(negedge clk);
      tick();
      tick();
      rstn = 1'b1;

      // Free run from reset, then a 2-cycle load-use stall holding 0x8.
      for (int i = 0; i < 7; i++) begin
         PCWr = vecs[i].pcwr;
         IF_ID_Wr = vecs[i].wr;
         #1;
         chk("vec req", 32'(imem_req), 32'(vecs[i].exp_req));
         chk("vec addr", imem_addr, vecs[i].exp_addr);
         chk("vec ifid pc", IF_ID_PC, vecs[i].exp_pc);
         chk("vec ifid valid", 32'(IF_ID_valid), 32'(vecs[i].exp_valid));
         chk("vec ifid inst", IF_ID_Inst, vecs[i].exp_valid ? memf(vecs[i].exp_pc) : NOP);
         tick();
      end
      wait_valid("after stall", 32'hC);
      wait_valid("after stall+1", 32'h10);

      // Flush while WAIT, stale 0x10 response one cycle later.
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      lat_now = 2;
      wait_accept(32'h10);
      flush = 1'b1; redirect_pc = 32'h100;
      tick();
      flush = 1'b0;
      chk("flush-wait bubble", 32'(IF_ID_valid), 32'd0);
      wait_valid("flush-wait target", 32'h100);

      // Flush coincident with the response.
      lat_now = 1;
      wait_accept(32'h108);
      flush = 1'b1; redirect_pc = 32'h100;
      tick();
      flush = 1'b0;
      chk("flush-rvalid bubble", 32'(IF_ID_valid), 32'd0);
      #1;
      chk("flush-rvalid req", 32'(imem_req), 32'd1);
      chk("flush-rvalid addr", imem_addr, 32'h100);
      wait_valid("flush-rvalid target", 32'h100);

      // Stall while the 0x20 response arrives.
      hits = 0; cnt_addr = 32'h20;
      flush = 1'b1; redirect_pc = 32'h20;
      tick();
      flush = 1'b0;
      wait_accept(32'h20);
      PCWr = 1'b0; IF_ID_Wr = 1'b0;
      tick();
      tick();
      PCWr = 1'b1; IF_ID_Wr = 1'b1;
      wait_valid("stall-resp 0x20", 32'h20);
      wait_valid("stall-resp 0x24", 32'h24);
      chk("fetches of 0x20", 32'(hits), 32'(EXP_HITS));
      cnt_addr = 32'h1;

      // PC wrap.
      flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      flush = 1'b0;
      wait_valid("wrap top", 32'hFFFF_FFFC);
      wait_valid("wrap zero", 32'h0);

      // Reset asserted mid-WAIT.
      lat_now = 3;
      wait_accept(32'h8);
      rstn = 1'b0;
      #1;
      chk("midreset req", 32'(imem_req), 32'd0);
      tick();
      chk("midreset rs1", 32'(IF_ID_Rs1), 32'd0);
      chk("midreset rs2", 32'(IF_ID_Rs2), 32'd0);
      rstn = 1'b1;
      #1;
      chk("midreset restart req", 32'(imem_req), 32'd1);
      chk("midreset restart addr", imem_addr, 32'h0);
      wait_valid("midreset first", 32'h0);
      wait_valid("midreset second", 32'h4);

      // Randomized run checked by the stream model inside tick().
      loads0 = loads;
      for (int i = 0; i < 2000; i++) begin
         imem_ready = ($urandom_range(0, 9) < 7);
         lat_now = $urandom_range(1, 3);
         PCWr = ($urandom_range(0, 99) >= 15);
         IF_ID_Wr = PCWr;
         flush = ($urandom_range(0, 99) < 4);
         r = $urandom();
         redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (r & 32'hFFFF_FFFC);
         rstn = ($urandom_range(0, 199) != 0);
         tick();
      end
      chk("random throughput", 32'((loads - loads0) > 150), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
